// File: rtl/wb_reg_bank_if.sv
// rtl/wb_reg_bank_if.sv - Wishbone pipelined bus bundle for wb_reg_bank
interface wb_reg_bank_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WIDTH      = 32
);
   logic                    wb_cyc_i;
   logic                    wb_stb_i;
   logic                    wb_we_i;
   logic [ADDR_WIDTH-1:0]   wb_adr_i;
   logic [WIDTH/8-1:0]      wb_sel_i;
   logic [WIDTH-1:0]        wb_dat_i;
   logic [WIDTH-1:0]        wb_dat_o;
   logic                    wb_ack_o;
   logic                    wb_err_o;
   logic                    wb_rty_o;
   logic                    wb_stall_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
   );
endinterface

// File: rtl/wb_reg_bank.sv
// rtl/wb_reg_bank.sv - Wishbone register bank (RW/RO regs, byte lanes, err on range); option WB_REG_BANK_PIPE_EN
module wb_reg_bank #(
   parameter int                       NREGS       = 4,
   parameter int                       WIDTH       = 32,
   parameter int                       ADDR_WIDTH  = 8,
   parameter logic [NREGS-1:0]         RO_MASK     = '0,
   parameter logic [NREGS*WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   wb_reg_bank_if.slave             wb,
   output logic [NREGS*WIDTH-1:0]   regs_o,
   input  logic [NREGS*WIDTH-1:0]   regs_i,
   output logic [NREGS-1:0]         wr_o
);

   localparam int                  NSEL    = WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] NREGS_W = (ADDR_WIDTH + 1)'(NREGS);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic             rd_busy, wr_busy;
   logic             ack_q, err_q;
   logic [WIDTH-1:0] dat_q;

   logic wb_en, acc_rd, acc_wr;
   logic pend_rd, pend_wr;

   // decode-side view of the write request and read-side view of the response
   logic                  d_wr_v;
   logic [ADDR_WIDTH-1:0] d_adr;
   logic [NSEL-1:0]       d_sel;
   logic [WIDTH-1:0]      d_dat;
   logic                  d_in_range;
   logic                  r_v, r_err;
   logic [WIDTH-1:0]      r_data;

   logic [WIDTH-1:0]      rd_val;
   logic                  bus_in_range;

   // RW slices of regs_i are deliberately not looked at
   wire unused_regs_i = ^regs_i;

   assign wb_en  = wb.wb_cyc_i & wb.wb_stb_i;
   assign acc_rd = wb_en & ~wb.wb_we_i & ~rd_busy;
   assign acc_wr = wb_en &  wb.wb_we_i & ~wr_busy;

   assign bus_in_range = ({1'b0, wb.wb_adr_i} < NREGS_W);
   assign d_in_range   = ({1'b0, d_adr} < NREGS_W);

   // read mux on the live bus address; no match (out of range) yields zero
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NREGS; k++) begin
         if (wb.wb_adr_i == ADDR_WIDTH'(k))
            rd_val = RO_MASK[k] ? regs_i[k*WIDTH +: WIDTH] : regs_q[k];
      end
   end

`ifdef WB_REG_BANK_PIPE_EN
   logic                  p_wr_v, p_rd_v, p_rd_err;
   logic [ADDR_WIDTH-1:0] p_adr;
   logic [NSEL-1:0]       p_sel;
   logic [WIDTH-1:0]      p_dat;
   logic [WIDTH-1:0]      p_rdata;

   // request/read-result stage ahead of decode and wb_dat_o
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p_wr_v   <= 1'b0;
         p_rd_v   <= 1'b0;
         p_rd_err <= 1'b0;
         p_adr    <= '0;
         p_sel    <= '0;
         p_dat    <= '0;
         p_rdata  <= '0;
      end else begin
         p_wr_v <= acc_wr;
         p_rd_v <= acc_rd;
         if (acc_wr) begin
            p_adr <= wb.wb_adr_i;
            p_sel <= wb.wb_sel_i;
            p_dat <= wb.wb_dat_i;
         end
         if (acc_rd) begin
            p_rdata  <= rd_val;
            p_rd_err <= ~bus_in_range;
         end
      end
   end

   assign d_wr_v  = p_wr_v;
   assign d_adr   = p_adr;
   assign d_sel   = p_sel;
   assign d_dat   = p_dat;
   assign r_v     = p_rd_v;
   assign r_err   = p_rd_err;
   assign r_data  = p_rdata;
   assign pend_rd = p_rd_v;
   assign pend_wr = p_wr_v;
`else
   assign d_wr_v  = acc_wr;
   assign d_adr   = wb.wb_adr_i;
   assign d_sel   = wb.wb_sel_i;
   assign d_dat   = wb.wb_dat_i;
   assign r_v     = acc_rd;
   assign r_err   = ~bus_in_range;
   assign r_data  = rd_val;
   assign pend_rd = 1'b0;
   assign pend_wr = 1'b0;
`endif

   // progress flags: one response per strobe phase; release once the phase ends and nothing is in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_busy <= 1'b0;
         wr_busy <= 1'b0;
      end else begin
         if (acc_rd)
            rd_busy <= 1'b1;
         else if (!wb_en && !pend_rd)
            rd_busy <= 1'b0;
         if (acc_wr)
            wr_busy <= 1'b1;
         else if (!wb_en && !pend_wr)
            wr_busy <= 1'b0;
      end
   end

   // register storage: byte-lane update of RW registers; RO registers stay at zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NREGS; k++)
            regs_q[k] <= RO_MASK[k] ? '0 : RESET_VALUE[k*WIDTH +: WIDTH];
      end else if (d_wr_v && d_in_range) begin
         for (int k = 0; k < NREGS; k++) begin
            if (!RO_MASK[k] && d_adr == ADDR_WIDTH'(k)) begin
               for (int b = 0; b < NSEL; b++) begin
                  if (d_sel[b])
                     regs_q[k][8*b +: 8] <= d_dat[8*b +: 8];
               end
            end
         end
      end
   end

   // single-cycle responses: ack/err, read data and per-register write strobes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
         wr_o  <= '0;
      end else begin
         ack_q <= (d_wr_v & d_in_range) | (r_v & ~r_err);
         err_q <= (d_wr_v & ~d_in_range) | (r_v & r_err);
         if (r_v)
            dat_q <= r_err ? '0 : r_data;
         for (int k = 0; k < NREGS; k++)
            wr_o[k] <= d_wr_v && d_in_range && (d_adr == ADDR_WIDTH'(k));
      end
   end

   for (genvar k = 0; k < NREGS; k++) begin : g_out
      assign regs_o[k*WIDTH +: WIDTH] = regs_q[k];
   end

   assign wb.wb_ack_o   = ack_q;
   assign wb.wb_err_o   = err_q;
   assign wb.wb_dat_o   = dat_q;
   assign wb.wb_rty_o   = 1'b0;
   assign wb.wb_stall_o = wb_en & ~(ack_q | err_q);

endmodule
